// File: rtl/proc_pkg.sv
// Shared opcodes, condition codes, bus selects and FSM step encodings
// for the flag-aware multicycle core.
package proc_pkg;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_LD  = 3'b100;
    localparam logic [2:0] OP_ST  = 3'b101;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_BCC = 3'b111;

    localparam logic [2:0] CC_AL = 3'b000;
    localparam logic [2:0] CC_EQ = 3'b001;
    localparam logic [2:0] CC_NE = 3'b010;
    localparam logic [2:0] CC_CC = 3'b011;
    localparam logic [2:0] CC_CS = 3'b100;
    localparam logic [2:0] CC_PL = 3'b101;
    localparam logic [2:0] CC_MI = 3'b110;

    typedef enum logic [2:0] {
        T0, T1, T2, T3, T4, T5, T6, T7
    } tstate_t;

    typedef enum logic [1:0] {
        ALU_ADD, ALU_SUB, ALU_AND
    } alu_op_t;

    typedef enum logic [2:0] {
        SEL_NONE, SEL_RY, SEL_IMM, SEL_MVT, SEL_G, SEL_DIN
    } bus_sel_t;

    function automatic logic cond_true(input logic [2:0] cc,
                                       input logic n, z, c);
        case (cc)
            CC_AL:   return 1'b1;
            CC_EQ:   return z;
            CC_NE:   return !z;
            CC_CC:   return !c;
            CC_CS:   return c;
            CC_PL:   return !n;
            CC_MI:   return n;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_n.sv
// DW-bit add/sub/and unit; C is the carry-out of the DW-bit adder
// (for sub, C=1 means no borrow), and C is always 0 for and.
module alu_n
    import proc_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  alu_op_t       op,
    output logic [DW-1:0] result,
    output logic          c,
    output logic          n,
    output logic          z
);

    logic [DW:0] sum;

    always_comb begin
        sum = '0;
        case (op)
            ALU_ADD: sum = {1'b0, a} + {1'b0, b};
            ALU_SUB: sum = {1'b0, a} + {1'b0, ~b} + (DW+1)'(1);
            ALU_AND: sum = {1'b0, a & b};
            default: sum = '0;
        endcase
    end

    assign result = sum[DW-1:0];
    assign c      = sum[DW];
    assign n      = sum[DW-1];
    assign z      = (sum[DW-1:0] == '0);

endmodule

// File: rtl/proc_flags_n.sv
// Multicycle core with N/Z/C flags and conditional relative branch;
// r7 is the pc, so any register write to r7 redirects fetch.
module proc_flags_n
    import proc_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 16
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Run,
    input  logic [DW-1:0] DIN,
    output logic [DW-1:0] DOUT,
    output logic [AW-1:0] ADDR,
    output logic          W,
    output logic          Done
);

    tstate_t       state;
    logic [15:0]   ir;
    logic [DW-1:0] rf [0:6];
    logic [AW-1:0] pc;
    logic [DW-1:0] a_reg, g_reg;
    logic          n_flag, z_flag, c_flag;

    logic [2:0]    op, rx, ry;
    logic          m, is_alu, illegal;
    logic [DW-1:0] imm, mvt_val, rx_val, ry_val, bus;
    logic [DW-1:0] alu_b, alu_res;
    logic          alu_c, alu_n_o, alu_z;
    alu_op_t       alu_op;
    bus_sel_t      sel;
    logic          wr_en, done_c;

    assign op      = ir[15:13];
    assign m       = ir[12];
    assign rx      = ir[11:9];
    assign ry      = ir[2:0];
    assign imm     = {{(DW-9){ir[8]}}, ir[8:0]};
    assign mvt_val = DW'({ir[7:0], 8'h00});
    assign rx_val  = (rx == 3'd7) ? DW'(pc) : rf[rx];
    assign ry_val  = (ry == 3'd7) ? DW'(pc) : rf[ry];
    assign is_alu  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    assign illegal = ((op == OP_MVT) && !m) ||
                     (((op == OP_LD) || (op == OP_ST)) && m);

    // Branches reuse the adder for pc + displacement
    assign alu_b  = ((op == OP_BCC) || m) ? imm : ry_val;
    assign alu_op = (op == OP_SUB) ? ALU_SUB :
                    (op == OP_AND) ? ALU_AND : ALU_ADD;

    alu_n #(.DW(DW)) u_alu (
        .a      (a_reg),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_res),
        .c      (alu_c),
        .n      (alu_n_o),
        .z      (alu_z)
    );

    always_comb begin
        sel    = SEL_NONE;
        wr_en  = 1'b0;
        done_c = 1'b0;
        case (state)
            T3: begin
                if (illegal) begin
                    done_c = 1'b1;
                end else if (op == OP_MV) begin
                    wr_en  = 1'b1;
                    sel    = m ? SEL_IMM : SEL_RY;
                    done_c = 1'b1;
                end else if (op == OP_MVT) begin
                    wr_en  = 1'b1;
                    sel    = SEL_MVT;
                    done_c = 1'b1;
                end
            end
            T4: done_c = (op == OP_ST);
            T5: begin
                done_c = 1'b1;
                if (is_alu) begin
                    wr_en = 1'b1;
                    sel   = SEL_G;
                end else if (op == OP_LD) begin
                    wr_en = 1'b1;
                    sel   = SEL_DIN;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus = '0;
        case (sel)
            SEL_RY:  bus = ry_val;
            SEL_IMM: bus = imm;
            SEL_MVT: bus = mvt_val;
            SEL_G:   bus = g_reg;
            SEL_DIN: bus = DIN;
            default: bus = '0;
        endcase
    end

    assign Done = done_c;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state  <= T0;
            pc     <= '0;
            ir     <= '0;
            a_reg  <= '0;
            g_reg  <= '0;
            DOUT   <= '0;
            ADDR   <= '0;
            W      <= 1'b0;
            n_flag <= 1'b0;
            z_flag <= 1'b0;
            c_flag <= 1'b0;
            for (int i = 0; i < 7; i++) rf[i] <= '0;
        end else begin
            W <= 1'b0;
            case (state)
                T0: if (Run) begin
                    ADDR  <= pc;
                    pc    <= pc + AW'(1);
                    state <= T1;
                end
                T1: state <= T2;
                T2: begin
                    ir    <= DIN[15:0];
                    state <= T3;
                end
                T3: if (done_c) begin
                    state <= T0;
                end else begin
                    state <= T4;
                    if (is_alu) a_reg <= rx_val;
                    if (op == OP_BCC) a_reg <= DW'(pc);
                    if ((op == OP_LD) || (op == OP_ST))
                        ADDR <= ry_val[AW-1:0];
                end
                T4: if (op == OP_ST) begin
                    DOUT  <= rx_val;
                    W     <= 1'b1;
                    state <= T0;
                end else begin
                    g_reg <= alu_res;
                    state <= T5;
                    if (is_alu) begin
                        n_flag <= alu_n_o;
                        z_flag <= alu_z;
                        c_flag <= alu_c;
                    end
                end
                T5: begin
                    state <= T0;
                    if ((op == OP_BCC) &&
                        cond_true(rx, n_flag, z_flag, c_flag))
                        pc <= g_reg[AW-1:0];
                end
                default: state <= T0;
            endcase
            // Register-file writes to r7 override the fetch increment
            if (wr_en) begin
                if (rx == 3'd7) pc <= bus[AW-1:0];
                else            rf[rx] <= bus;
            end
        end
    end

endmodule

// File: tb/tb_proc_flags_n.sv
// Directed bench: one DW=16/AW=16 core and one DW=32/AW=12 core, each
// on a small synchronous memory model with one-cycle read latency.
module tb_proc_flags_n;
    import proc_pkg::*;

    logic        Clock = 1'b0;
    logic        Resetn0, Run0, W0, Done0;
    logic [15:0] DIN0, DOUT0, ADDR0;
    logic        Resetn1, Run1, W1, Done1;
    logic [31:0] DIN1, DOUT1;
    logic [11:0] ADDR1;

    logic [15:0] mem0 [0:255];
    logic [15:0] mem1 [0:255];

    int checks   = 0;
    int failures = 0;

    always #5 Clock = ~Clock;

    proc_flags_n #(.DW(16), .AW(16)) u0 (
        .Clock(Clock), .Resetn(Resetn0), .Run(Run0), .DIN(DIN0),
        .DOUT(DOUT0), .ADDR(ADDR0), .W(W0), .Done(Done0)
    );

    proc_flags_n #(.DW(32), .AW(12)) u1 (
        .Clock(Clock), .Resetn(Resetn1), .Run(Run1), .DIN(DIN1),
        .DOUT(DOUT1), .ADDR(ADDR1), .W(W1), .Done(Done1)
    );

    always @(posedge Clock) begin
        if (W0) mem0[ADDR0[7:0]] <= DOUT0;
        DIN0 <= mem0[ADDR0[7:0]];
        if (W1) mem1[ADDR1[7:0]] <= DOUT1[15:0];
        DIN1 <= {16'h0000, mem1[ADDR1[7:0]]};
    end

    function automatic logic [15:0] enc(input int iii, m, x, d);
        logic [2:0] i3, x3;
        logic [8:0] d9;
        i3 = iii[2:0];
        x3 = x[2:0];
        d9 = d[8:0];
        return {i3, m[0], x3, d9};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for Done of the selected core, then steps past the edge
    task automatic run_instr(input int which, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge Clock);
            seen = (which == 0) ? Done0 : Done1;
        end
        checks++;
        assert (seen === 1'b1) else begin
            failures++;
            $error("FAIL %s_done observed=0 expected=1", tag);
        end
        @(posedge Clock);
        #1;
    endtask

    initial begin
        logic seen;
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 16'h0000;
            mem1[i] = 16'h0000;
        end
        mem0[0]  = enc(0, 1, 0, 'h1FF);
        mem0[1]  = enc(2, 1, 0, 1);
        mem0[2]  = enc(0, 1, 1, 1);
        mem0[3]  = enc(3, 1, 1, 2);
        mem0[4]  = enc(7, 0, 3, 3);
        mem0[8]  = enc(7, 0, 4, 5);
        mem0[9]  = enc(1, 1, 2, 'h012);
        mem0[10] = enc(0, 1, 3, 'h040);
        mem0[11] = enc(5, 0, 2, 3);
        mem0[12] = enc(4, 0, 4, 3);
        mem0[13] = enc(2, 1, 1, 1);
        mem0[14] = enc(6, 1, 4, 'h0FF);
        mem0[15] = enc(4, 0, 5, 3);
        mem1[0]  = enc(0, 1, 5, 'h1FF);
        mem1[1]  = enc(0, 0, 7, 5);

        Resetn0 = 1'b0; Run0 = 1'b0;
        Resetn1 = 1'b0; Run1 = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check("rst_pc", 64'(u0.pc), 64'h0);
        check("rst_state", 64'(u0.state), 64'(T0));
        check("rst_w", 64'(W0), 64'h0);
        check("rst_addr", 64'(ADDR0), 64'h0);
        check("rst_dout", 64'(DOUT0), 64'h0);
        check("rst_flags", 64'({u0.n_flag, u0.z_flag, u0.c_flag}), 64'h0);

        Resetn0 = 1'b1; Run0 = 1'b1;
        run_instr(0, "mv_r0");
        check("mv_r0", 64'(u0.rf[0]), 64'hFFFF);
        run_instr(0, "add_r0");
        check("add_r0", 64'(u0.rf[0]), 64'h0000);
        check("add_nzc", 64'({u0.n_flag, u0.z_flag, u0.c_flag}), 64'b011);
        run_instr(0, "mv_r1");
        run_instr(0, "sub_r1");
        check("sub_r1", 64'(u0.rf[1]), 64'hFFFF);
        check("sub_nzc", 64'({u0.n_flag, u0.z_flag, u0.c_flag}), 64'b100);
        run_instr(0, "bcc");
        check("bcc_pc", 64'(u0.pc), 64'h0008);
        run_instr(0, "bcs");
        check("bcs_pc", 64'(u0.pc), 64'h0009);
        check("bcs_flags", 64'({u0.n_flag, u0.z_flag, u0.c_flag}), 64'b100);
        run_instr(0, "mvt_r2");
        check("mvt_r2", 64'(u0.rf[2]), 64'h1200);
        run_instr(0, "mv_r3");
        run_instr(0, "st");
        check("st_w", 64'(W0), 64'h1);
        check("st_addr", 64'(ADDR0), 64'h0040);
        check("st_dout", 64'(DOUT0), 64'h1200);
        @(posedge Clock);
        #1;
        check("st_w_off", 64'(W0), 64'h0);
        run_instr(0, "ld_r4");
        check("ld_r4", 64'(u0.rf[4]), 64'h1200);
        run_instr(0, "add_r1");
        check("add_r1", 64'(u0.rf[1]), 64'h0000);
        check("add1_nzc", 64'({u0.n_flag, u0.z_flag, u0.c_flag}), 64'b011);
        run_instr(0, "and_r4");
        check("and_r4", 64'(u0.rf[4]), 64'h0000);
        check("and_nzc", 64'({u0.n_flag, u0.z_flag, u0.c_flag}), 64'b010);

        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge Clock);
            seen = (u0.state == T4);
        end
        check("ld_reach_t4", 64'(seen), 64'h1);
        Resetn0 = 1'b0; Run0 = 1'b0;
        @(posedge Clock);
        #1;
        check("abort_state", 64'(u0.state), 64'(T0));
        check("abort_pc", 64'(u0.pc), 64'h0);
        check("abort_r2", 64'(u0.rf[2]), 64'h0);
        check("abort_r5", 64'(u0.rf[5]), 64'h0);
        check("abort_flags", 64'({u0.n_flag, u0.z_flag, u0.c_flag}), 64'h0);
        check("abort_w", 64'(W0), 64'h0);

        mem0[0] = enc(7, 0, 0, 'h1FF);
        Resetn0 = 1'b1; Run0 = 1'b1;
        run_instr(0, "loop1");
        check("loop1_pc", 64'(u0.pc), 64'h0000);
        run_instr(0, "loop2");
        check("loop2_pc", 64'(u0.pc), 64'h0000);
        Run0 = 1'b0;
        mem0[0]   = enc(0, 1, 7, 'h1FF);
        mem0[255] = enc(7, 0, 0, 'h1FE);
        @(posedge Clock);
        #1;
        Run0 = 1'b1;
        run_instr(0, "mv_pc");
        check("mv_pc", 64'(u0.pc), 64'hFFFF);
        run_instr(0, "bwrap");
        check("bwrap_pc", 64'(u0.pc), 64'hFFFE);
        Run0 = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        check("idle0_state", 64'(u0.state), 64'(T0));
        check("idle0_pc", 64'(u0.pc), 64'hFFFE);

        Resetn1 = 1'b1; Run1 = 1'b1;
        run_instr(1, "w32_mv_r5");
        check("w32_r5", 64'(u1.rf[5]), 64'hFFFF_FFFF);
        run_instr(1, "w32_mv_pc");
        check("w32_pc", 64'(u1.pc), 64'h0FFF);
        Run1 = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        check("w32_idle_state", 64'(u1.state), 64'(T0));
        check("w32_idle_pc", 64'(u1.pc), 64'h0FFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
